memory_stage: RTL and testbench

//  MEM stage of the 5-stage MIPS pipeline. Consumes the EX/MEM latch from execute_stage, runs the

---
 rtl/memory_stage_pkg.sv | 47 ++++
 rtl/memory_stage_if.sv | 23 ++
 rtl/memory_stage_ll_sc_link.sv | 44 ++++
 rtl/memory_stage.sv | 128 ++++++++++++
 tb/tb_memory_stage.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_stage_pkg.sv
// Shared types for the MEM stage: pipeline latch structs, FSM state codes and the LL/SC link record.
package memory_stage_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef logic [1:0] mem_state_t;
  localparam mem_state_t IDLE = 2'd0;
  localparam mem_state_t BUSY = 2'd1;
  localparam mem_state_t DONE = 2'd2;

  typedef struct packed {
    logic     dREN;
    logic     dWEN;
    logic     LL;
    logic     SC;
    word_t    PC;
    regbits_t Rw;
    logic     RegWEN;
    logic     MemtoReg;
    logic     halt;
    word_t    NPC;
    word_t    port_o;
    word_t    port_b;
    word_t    Imm_Ext;
  } execute_t;

  typedef struct packed {
    regbits_t Rw;
    logic     RegWEN;
    logic     MemtoReg;
    logic     halt;
    word_t    NPC;
    word_t    port_o;
    word_t    dload;
    word_t    PC;
  } memory_t;

  typedef struct packed {
    logic  valid;
    word_t addr;
  } link_t;

endpackage

// File: rtl/memory_stage_if.sv
// Data-cache handshake between the MEM stage (master) and the dcache (slave), incl. coherence snoop.
interface memory_stage_if;
  import memory_stage_pkg::*;

  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  dhit;
  word_t dmemload;
  logic  ccinv;
  word_t ccsnoopaddr;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload, ccinv, ccsnoopaddr
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload, ccinv, ccsnoopaddr
  );
endinterface

// File: rtl/memory_stage_ll_sc_link.sv
// LL/SC link register: set by a completed LL, cleared by SC, snoop invalidate or own store to the address.
module memory_stage_ll_sc_link
  import memory_stage_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ll_set,
  input  word_t set_addr,
  input  logic  sc_clear,
  input  logic  sw_hit,
  input  word_t sw_addr,
  input  logic  ccinv,
  input  word_t ccsnoopaddr,
  input  word_t cmp_addr,
  output logic  link_hit
);

  link_t link_reg;
  link_t link_next;
  logic  clear;

  assign clear = sc_clear
               | (ccinv  & (ccsnoopaddr == link_reg.addr))
               | (sw_hit & (sw_addr     == link_reg.addr));

  // A clear in the same cycle as an LL completion wins, so a racing invalidate is never lost.
  always_comb begin
    link_next = link_reg;
    if (clear)
      link_next.valid = 1'b0;
    else if (ll_set)
      link_next = '{valid: 1'b1, addr: set_addr};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      link_reg <= '0;
    else
      link_reg <= link_next;
  end

  assign link_hit = link_reg.valid & (link_reg.addr == cmp_addr);

endmodule

// File: rtl/memory_stage.sv
// MEM stage: dcache request/handshake FSM, LL/SC resolution, stall generation and the MEM/WB latch.
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  execute_t ex_p,
  input  logic     ihit,
  input  logic     flush,
  memory_stage_if.master dif,
  output logic     mem_stall,
  output memory_t  memory_p,
  output word_t    FW_memory_data
);

  mem_state_t state_reg;
  mem_state_t state_next;
  word_t      load_buf_reg;
  logic       sc_pass_reg;
  memory_t    memory_reg;
  memory_t    memory_next;
  memory_t    entry;

  logic  link_hit;
  logic  eff_wen;
  logic  acc;
  logic  not_done;
  logic  dhit_eff;
  logic  sc_result;
  word_t dload_now;

  // A failing SC never reaches the cache: it is resolved locally as a zero result.
  assign eff_wen  = ex_p.dWEN & (~ex_p.SC | link_hit);
  assign acc      = ex_p.dREN | eff_wen;
  assign not_done = (state_reg != DONE);
  assign dhit_eff = dif.dhit & not_done;

  assign dif.dmemREN   = nRST & ex_p.dREN & not_done;
  assign dif.dmemWEN   = nRST & eff_wen & not_done;
  assign dif.dmemaddr  = ex_p.port_o;
  assign dif.dmemstore = ex_p.port_b;
  assign mem_stall     = nRST & acc & not_done & ~dif.dhit;

  memory_stage_ll_sc_link u_link (
    .CLK         (CLK),
    .nRST        (nRST),
    .ll_set      (ex_p.LL & ex_p.dREN & dhit_eff),
    .set_addr    (ex_p.port_o),
    .sc_clear    (ex_p.SC & not_done & (~link_hit | dif.dhit)),
    .sw_hit      (ex_p.dWEN & ~ex_p.SC & dhit_eff),
    .sw_addr     (ex_p.port_o),
    .ccinv       (dif.ccinv),
    .ccsnoopaddr (dif.ccsnoopaddr),
    .cmp_addr    (ex_p.port_o),
    .link_hit    (link_hit)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (acc)       state_next = dif.dhit ? DONE : BUSY;
      BUSY:    if (dif.dhit)  state_next = DONE;
      DONE:    if (ihit)      state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      load_buf_reg <= '0;
    else if (dhit_eff & ex_p.dREN)
      load_buf_reg <= dif.dmemload;
  end

  // The link is cleared by the SC's own completion, so its outcome is remembered while parked in DONE.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      sc_pass_reg <= 1'b0;
    else if (not_done)
      sc_pass_reg <= ex_p.SC & eff_wen & dif.dhit;
  end

  assign sc_result = not_done ? (eff_wen & dif.dhit) : sc_pass_reg;
  assign dload_now = dhit_eff ? dif.dmemload : load_buf_reg;

  always_comb begin
    entry          = '0;
    entry.Rw       = ex_p.Rw;
    entry.RegWEN   = ex_p.RegWEN;
    entry.MemtoReg = ex_p.MemtoReg & ~ex_p.SC;
    entry.halt     = ex_p.halt | memory_reg.halt;
    entry.NPC      = ex_p.NPC;
    entry.port_o   = ex_p.SC ? {{(WORD_W-1){1'b0}}, sc_result} : ex_p.port_o;
    entry.dload    = dload_now;
    entry.PC       = ex_p.PC;
  end

  // Halt is sticky: a flush squashes everything except an already-latched halt.
  always_comb begin
    memory_next = memory_reg;
    if (flush) begin
      memory_next      = '0;
      memory_next.halt = memory_reg.halt;
    end else if (mem_stall) begin
      memory_next = memory_reg;
    end else if (ihit) begin
      memory_next = entry;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      memory_reg <= '0;
    else
      memory_reg <= memory_next;
  end

  assign memory_p       = memory_reg;
  assign FW_memory_data = memory_reg.MemtoReg ? memory_reg.dload : memory_reg.port_o;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: loads, stores, LL/SC link cases, flush/halt and reset mid-access.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic     CLK = 1'b0;
  logic     nRST;
  execute_t ex_p;
  logic     ihit;
  logic     flush;
  logic     mem_stall;
  memory_t  memory_p;
  word_t    FW_memory_data;

  int n_tests = 0;
  int n_fail  = 0;

  memory_stage_if dif();

  memory_stage dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .ex_p           (ex_p),
    .ihit           (ihit),
    .flush          (flush),
    .dif            (dif),
    .mem_stall      (mem_stall),
    .memory_p       (memory_p),
    .FW_memory_data (FW_memory_data)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic retire();
    ihit = 1'b1;
    step();
    ihit = 1'b0;
    ex_p = '0;
    #1;
  endtask

  function automatic execute_t mk(input logic rd, input logic wr, input logic ll, input logic sc,
                                  input logic m2r, input logic [4:0] rw, input word_t addr,
                                  input word_t store);
    execute_t e;
    e          = '0;
    e.dREN     = rd;
    e.dWEN     = wr;
    e.LL       = ll;
    e.SC       = sc;
    e.MemtoReg = m2r;
    e.Rw       = rw;
    e.RegWEN   = (rw != 5'd0);
    e.port_o   = addr;
    e.port_b   = store;
    e.PC       = 32'h0000_0400 + addr;
    e.NPC      = 32'h0000_0404 + addr;
    return e;
  endfunction

  task automatic do_ll(input word_t addr, input word_t data);
    ex_p = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2, addr, 32'h0);
    dif.dhit = 1'b1;
    dif.dmemload = data;
    #1;
    check("ll_ren", 32'(dif.dmemREN), 32'd1);
    step();
    dif.dhit = 1'b0;
    dif.dmemload = '0;
    retire();
    check("ll_dload", memory_p.dload, data);
  endtask

  task automatic do_sc(input word_t addr, input logic ok);
    ex_p = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, addr, 32'h77);
    dif.dhit = ok;
    #1;
    check("sc_wen", 32'(dif.dmemWEN), 32'(ok));
    check("sc_stall", 32'(mem_stall), 32'd0);
    step();
    dif.dhit = 1'b0;
    retire();
    check("sc_result", memory_p.port_o, 32'(ok));
    check("sc_m2r", 32'(memory_p.MemtoReg), 32'd0);
    check("sc_fw", FW_memory_data, 32'(ok));
  endtask

  task automatic snoop(input word_t addr);
    ex_p = '0;
    dif.ccinv = 1'b1;
    dif.ccsnoopaddr = addr;
    step();
    dif.ccinv = 1'b0;
    dif.ccsnoopaddr = '0;
  endtask

  initial begin
    nRST = 1'b0;
    ex_p = '0;
    ihit = 1'b0;
    flush = 1'b0;
    dif.dhit = 1'b0;
    dif.dmemload = '0;
    dif.ccinv = 1'b0;
    dif.ccsnoopaddr = '0;
    step();
    step();
    check("rst_memp", 32'(|memory_p), 32'd0);
    check("rst_ren", 32'(dif.dmemREN), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    nRST = 1'b1;
    #1;
    check("rst_fw", FW_memory_data, 32'd0);

    // LW with three stalled cycles, then dhit; ihit while stalled must not load the latch
    ex_p = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h100, 32'h0);
    #1;
    check("lw_ren_c1", 32'(dif.dmemREN), 32'd1);
    check("lw_addr", dif.dmemaddr, 32'h100);
    check("lw_stall_c1", 32'(mem_stall), 32'd1);
    step();
    ihit = 1'b1;
    #1;
    check("lw_stall_c2", 32'(mem_stall), 32'd1);
    step();
    ihit = 1'b0;
    #1;
    check("lw_hold_rw", 32'(memory_p.Rw), 32'd0);
    check("lw_stall_c3", 32'(mem_stall), 32'd1);
    check("lw_ren_c3", 32'(dif.dmemREN), 32'd1);
    step();
    dif.dhit = 1'b1;
    dif.dmemload = 32'hDEAD_BEEF;
    #1;
    check("lw_stall_hit", 32'(mem_stall), 32'd0);
    step();
    dif.dhit = 1'b0;
    dif.dmemload = '0;
    #1;
    check("lw_ren_done", 32'(dif.dmemREN), 32'd0);
    retire();
    check("lw_dload", memory_p.dload, 32'hDEAD_BEEF);
    check("lw_m2r", 32'(memory_p.MemtoReg), 32'd1);
    check("lw_rw", 32'(memory_p.Rw), 32'd5);
    check("lw_fw", FW_memory_data, 32'hDEAD_BEEF);

    // SW completing in the same cycle
    ex_p = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h200, 32'h1234);
    dif.dhit = 1'b1;
    #1;
    check("sw_wen", 32'(dif.dmemWEN), 32'd1);
    check("sw_store", dif.dmemstore, 32'h1234);
    check("sw_stall", 32'(mem_stall), 32'd0);
    step();
    dif.dhit = 1'b0;
    #1;
    check("sw_wen_done", 32'(dif.dmemWEN), 32'd0);
    retire();
    check("sw_port_o", memory_p.port_o, 32'h200);
    check("sw_fw", FW_memory_data, 32'h200);

    // LL/SC: success, link consumed, snoop to other address, snoop hit, own store clears
    do_ll(32'h300, 32'h55);
    do_sc(32'h300, 1'b1);
    do_sc(32'h300, 1'b0);
    do_ll(32'h300, 32'h66);
    snoop(32'h304);
    do_sc(32'h300, 1'b1);
    do_ll(32'h300, 32'h77);
    snoop(32'h300);
    do_sc(32'h300, 1'b0);
    do_ll(32'h300, 32'h88);
    ex_p = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h300, 32'h9);
    dif.dhit = 1'b1;
    step();
    dif.dhit = 1'b0;
    retire();
    do_sc(32'h300, 1'b0);

    // flush during BUSY, then retire the load, then sticky halt
    ex_p = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 32'h100, 32'h0);
    step();
    flush = 1'b1;
    #1;
    check("fl_stall", 32'(mem_stall), 32'd1);
    step();
    flush = 1'b0;
    #1;
    check("fl_memp", 32'(|memory_p), 32'd0);
    dif.dhit = 1'b1;
    dif.dmemload = 32'hCAFE_F00D;
    step();
    dif.dhit = 1'b0;
    dif.dmemload = '0;
    retire();
    check("fl_dload", memory_p.dload, 32'hCAFE_F00D);
    ex_p.halt = 1'b1;
    retire();
    check("halt_set", 32'(memory_p.halt), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check("halt_flush", 32'(memory_p.halt), 32'd1);
    check("halt_flush_pc", memory_p.PC, 32'd0);
    retire();
    check("halt_bubble", 32'(memory_p.halt), 32'd1);

    // reset while BUSY
    ex_p = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h100, 32'h0);
    step();
    #1;
    check("rb_ren", 32'(dif.dmemREN), 32'd1);
    nRST = 1'b0;
    #1;
    check("rb_ren_rst", 32'(dif.dmemREN), 32'd0);
    check("rb_stall_rst", 32'(mem_stall), 32'd0);
    check("rb_memp", 32'(|memory_p), 32'd0);
    step();
    nRST = 1'b1;
    ex_p = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h200, 32'h4321);
    dif.dhit = 1'b1;
    #1;
    check("rb_wen_after", 32'(dif.dmemWEN), 32'd1);
    check("rb_stall_after", 32'(mem_stall), 32'd0);
    step();
    dif.dhit = 1'b0;
    retire();
    check("rb_port_o", memory_p.port_o, 32'h200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
